heap_sort_ctrl: RTL and testbench

- Sequential heap-sort engine over a register-file heap of N signed W-bit keys.
- Loads a vector and builds a min-heap by repeated sift-down, one tree level per cycle.
- Then repeatedly swaps the root to the tail and sifts again, leaving the vector in descending order.
- Sequences the combinational swap-index function as its only compare datapath. Sits between the HeapSort top level and its load/unload interface.

---
 rtl/heap_sort_pkg.sv | 24 ++
 rtl/heap_swap_idx.sv | 46 ++++
 rtl/heap_sort_ctrl.sv | 146 ++++++++++++++
 tb/tb_heap_sort_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/heap_sort_pkg.sv
// Shared types and defaults for the heap-sort engine: key/index types,
// FSM state and phase encodings.
package heap_sort_pkg;

    localparam int N_DEF  = 5;
    localparam int W_DEF  = 32;
    localparam int IW_DEF = 16;

    typedef logic signed [W_DEF-1:0] key_t;
    typedef logic [IW_DEF-1:0]       idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SIFT    = 2'd1,
        EXTRACT = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        BUILD = 1'b0,
        SORT  = 1'b1
    } phase_t;

endpackage

// File: rtl/heap_swap_idx.sv
// Combinational min-heap swap index: picks the smallest of parent and its
// in-range children, ties resolved toward the parent, then the left child.
module heap_swap_idx
    import heap_sort_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic signed [W-1:0] heap [N],
    input  logic [IW-1:0]       cur,
    input  logic [IW-1:0]       size,
    output logic [IW-1:0]       s
);

    logic [IW-1:0]       c1;
    logic [IW-1:0]       c2;
    logic signed [W-1:0] k_cur;
    logic signed [W-1:0] k_c1;
    logic signed [W-1:0] k_c2;
    logic signed [W-1:0] k_best;

    always_comb begin
        c1     = (cur << 1) + IW'(1);
        c2     = (cur << 1) + IW'(2);
        k_cur  = '0;
        k_c1   = '0;
        k_c2   = '0;
        for (int k = 0; k < N; k++) begin
            if (cur == IW'(k)) k_cur = heap[k];
            if (c1 == IW'(k))  k_c1  = heap[k];
            if (c2 == IW'(k))  k_c2  = heap[k];
        end
        // Strict greater-than keeps the earlier candidate on ties
        s      = cur;
        k_best = k_cur;
        if (c1 < size && k_best > k_c1) begin
            s      = c1;
            k_best = k_c1;
        end
        if (c2 < size && k_best > k_c2) begin
            s = c2;
        end
    end

endmodule

// File: rtl/heap_sort_ctrl.sv
// Sequential heap-sort controller: builds a min-heap then extracts to the tail,
// leaving keys in descending order. Define HEAP_SORT_CYCLE_CNT_EN for cycles_o.
module heap_sort_ctrl
    import heap_sort_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic           system1000,
    input  logic           system1000_rst,
    input  logic           start_i,
    input  logic [N*W-1:0] data_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N*W-1:0] data_o,
    output logic [IW-1:0]  cycles_o
);

    state_t              state;
    state_t              state_n;
    phase_t              phase;
    logic signed [W-1:0] heap [N];
    logic [IW-1:0]       size;
    logic [IW-1:0]       cur;
    logic [IW-1:0]       b;
    logic [IW-1:0]       s;
    logic [IW-1:0]       tail;
    logic signed [W-1:0] cur_val;
    logic signed [W-1:0] s_val;
    logic signed [W-1:0] tail_val;

    heap_swap_idx #(.N(N), .W(W), .IW(IW)) u_swap_idx (
        .heap (heap),
        .cur  (cur),
        .size (size),
        .s    (s)
    );

    always_comb begin
        tail     = size - IW'(1);
        cur_val  = '0;
        s_val    = '0;
        tail_val = '0;
        for (int k = 0; k < N; k++) begin
            if (cur == IW'(k))  cur_val  = heap[k];
            if (s == IW'(k))    s_val    = heap[k];
            if (tail == IW'(k)) tail_val = heap[k];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = SIFT;
            SIFT:    if (s == cur && (phase == SORT || b == '0)) state_n = EXTRACT;
            EXTRACT: state_n = (size == IW'(1)) ? DONE : SIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state == SIFT) || (state == EXTRACT);
    assign done_o = (state == DONE);

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            for (int k = 0; k < N; k++) heap[k] <= '0;
            data_o <= '0;
            size   <= '0;
            cur    <= '0;
            b      <= '0;
            phase  <= BUILD;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < N; k++) heap[k] <= data_i[(N-1-k)*W +: W];
                        size  <= IW'(N);
                        b     <= IW'(N/2 - 1);
                        cur   <= IW'(N/2 - 1);
                        phase <= BUILD;
                    end
                end
                SIFT: begin
                    if (s != cur) begin
                        for (int k = 0; k < N; k++) begin
                            if (cur == IW'(k))    heap[k] <= s_val;
                            else if (s == IW'(k)) heap[k] <= cur_val;
                        end
                        cur <= s;
                    end else if (phase == BUILD && b != '0) begin
                        b   <= b - IW'(1);
                        cur <= b - IW'(1);
                    end
                end
                EXTRACT: begin
                    if (size == IW'(1)) begin
                        for (int k = 0; k < N; k++) data_o[(N-1-k)*W +: W] <= heap[k];
                    end else begin
                        // size >= 2 here, so the tail never aliases the root
                        for (int k = 0; k < N; k++) begin
                            if (k == 0)              heap[k] <= tail_val;
                            else if (tail == IW'(k)) heap[k] <= heap[0];
                        end
                        size  <= tail;
                        cur   <= '0;
                        phase <= SORT;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HEAP_SORT_CYCLE_CNT_EN
    logic [IW-1:0] cnt;

    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
        return (&v) ? v : v + IW'(1);
    endfunction

    // The EXTRACT cycle that enters DONE is itself busy, hence sat_inc on the copy
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            cnt      <= '0;
            cycles_o <= '0;
        end else begin
            if (state == IDLE && start_i) cnt <= '0;
            else if (busy_o)              cnt <= sat_inc(cnt);
            if (state == EXTRACT && state_n == DONE) cycles_o <= sat_inc(cnt);
        end
    end
`else
    assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Self-checking bench for heap_sort_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized sorts against a sorting reference model.
module tb_heap_sort_ctrl;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int IW = 16;
    localparam int MAX_BUSY = N/2 + (N-1) + N*$clog2(N) + 1;

    logic           system1000;
    logic           system1000_rst;
    logic           start_i;
    logic [N*W-1:0] data_i;
    logic           busy_o;
    logic           done_o;
    logic [N*W-1:0] data_o;
    logic [IW-1:0]  cycles_o;

    int errors = 0;
    int checks = 0;

    heap_sort_ctrl #(.N(N), .W(W), .IW(IW)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .start_i        (start_i),
        .data_i         (data_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .data_o         (data_o),
        .cycles_o       (cycles_o)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    typedef struct {
        logic [N*W-1:0] din;
        logic [N*W-1:0] dout;
        int             done_at;
    } vec_t;

    function automatic logic [N*W-1:0] pack(input logic signed [W-1:0] a0, a1, a2, a3, a4);
        return {a0, a1, a2, a3, a4};
    endfunction

    // Reference: plain descending sort of the signed keys
    function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] din);
        logic signed [W-1:0] a [N];
        logic signed [W-1:0] t;
        logic [N*W-1:0]      r;
        for (int k = 0; k < N; k++) a[k] = din[(N-1-k)*W +: W];
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (a[j] > a[i]) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
        for (int k = 0; k < N; k++) r[(N-1-k)*W +: W] = a[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Caller is #1 into cycle 1 after the accepting edge.
    task automatic wait_done(output int done_cyc, output int busy_cnt);
        int cyc;
        cyc      = 1;
        busy_cnt = 0;
        done_cyc = -1;
        while (cyc <= 200) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            @(posedge system1000); #1;
            cyc++;
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done_o got=none exp=pulse");
        end
    endtask

    task automatic start_sort(input logic [N*W-1:0] din);
        @(negedge system1000);
        data_i  = din;
        start_i = 1'b1;
        @(posedge system1000); #1;
        start_i = 1'b0;
    endtask

    task automatic check_cycles(input string name, input int busy_cnt);
`ifdef HEAP_SORT_CYCLE_CNT_EN
        chk(name, N*W'(cycles_o), N*W'(busy_cnt));
`else
        chk(name, N*W'(cycles_o), '0);
`endif
    endtask

    vec_t           vecs [6];
    int             dc;
    int             bc;
    logic [N*W-1:0] din;
    logic [N*W-1:0] prev;
    logic [N*W-1:0] pat_b;
    bit             stale_ok;

    initial begin
        vecs[0] = '{pack(7, 7, 7, 7, 7), pack(7, 7, 7, 7, 7), 12};
        vecs[1] = '{pack(1, 2, 3, 4, 5), pack(5, 4, 3, 2, 1), -1};
        vecs[2] = '{pack(-3, 10, 0, -32768, 4), pack(10, 4, 0, -3, -32768), -1};
        vecs[3] = '{pack(2, 1, 2, 1, 2), pack(2, 2, 2, 1, 1), -1};
        vecs[4] = '{pack(32'sh7fffffff, 32'sh80000000, -1, 0, 1),
                    pack(32'sh7fffffff, 1, 0, -1, 32'sh80000000), -1};
        vecs[5] = '{pack(5, 4, 3, 2, 1), pack(5, 4, 3, 2, 1), -1};

        system1000_rst = 1'b1;
        start_i        = 1'b0;
        data_i         = '0;
        repeat (2) @(posedge system1000);
        #1;
        chk("reset_outputs", {busy_o, done_o, data_o, cycles_o}, '0);
        @(negedge system1000);
        system1000_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_sort(vecs[i].din);
            wait_done(dc, bc);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].dout);
            chk($sformatf("vec%0d_busy_done", i), N*W'({busy_o, done_o}), N*W'(2'b01));
            if (vecs[i].done_at >= 0) begin
                chk($sformatf("vec%0d_latency", i), N*W'(dc), N*W'(vecs[i].done_at));
`ifdef HEAP_SORT_CYCLE_CNT_EN
                chk($sformatf("vec%0d_cycles", i), N*W'(cycles_o), N*W'(11));
`else
                chk($sformatf("vec%0d_cycles", i), N*W'(cycles_o), '0);
`endif
            end else begin
                check_cycles($sformatf("vec%0d_cycles", i), bc);
            end
            @(posedge system1000); #1;
            chk($sformatf("vec%0d_after_done", i), N*W'({busy_o, done_o}), '0);
        end

        // Restart requests during a sort are dropped; data_o stays stale until DONE
        prev  = data_o;
        din   = pack(9, -1, 3, 0, 2);
        pat_b = pack(3, 3, 3, 3, 3);
        start_sort(din);
        stale_ok = 1'b1;
        dc = 1;
        while (!done_o && dc <= 200) begin
            if (data_o !== prev) stale_ok = 1'b0;
            if (dc == 3) begin
                start_i = 1'b1;
                data_i  = pat_b;
            end
            @(posedge system1000); #1;
            dc++;
        end
        chk("busy_restart_stale", N*W'(stale_ok), N*W'(1));
        chk("busy_restart_done", N*W'(done_o), N*W'(1));
        chk("busy_restart_data", data_o, model_sort(din));
        @(posedge system1000); #1;
        chk("idle_after_done", N*W'({busy_o, done_o}), '0);
        @(posedge system1000); #1;
        chk("accept_after_idle", N*W'(busy_o), N*W'(1));
        start_i = 1'b0;
        wait_done(dc, bc);
        chk("second_sort_data", data_o, pat_b);
        chk("second_sort_latency", N*W'(dc), N*W'(12));
        @(posedge system1000); #1;

        // Asynchronous reset mid-sort
        start_sort(pack(1, 2, 3, 4, 5));
        repeat (4) @(posedge system1000);
        #2;
        system1000_rst = 1'b1;
        #1;
        chk("async_reset", {busy_o, done_o, data_o, cycles_o}, '0);
        @(negedge system1000);
        system1000_rst = 1'b0;
        start_sort(pack(2, 1, 2, 1, 2));
        wait_done(dc, bc);
        chk("post_reset_data", data_o, pack(2, 2, 2, 1, 1));
        @(posedge system1000); #1;

        // Randomized sorts, half with narrow ranges to force ties
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N; k++) begin
                if (r % 2 == 0) din[k*W +: W] = $urandom;
                else            din[k*W +: W] = W'($urandom_range(0, 6)) - W'(3);
            end
            start_sort(din);
            wait_done(dc, bc);
            chk($sformatf("rand%0d_data", r), data_o, model_sort(din));
            chk($sformatf("rand%0d_busy_bound", r),
                N*W'((bc >= 11 && bc <= MAX_BUSY) ? 1 : 0), N*W'(1));
            check_cycles($sformatf("rand%0d_cycles", r), bc);
            @(posedge system1000); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
